// File: rtl/led_pattern_ctrl.sv
// Button-driven LED pattern generator: debounced mode/speed/pause controls and
// a prescaled stepper producing shift, bounce and fill patterns on 8 LEDs.
module led_pattern_ctrl #(
  parameter int DEB_CYCLES  = 2000000,
  parameter int BASE_PERIOD = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused,
  output logic       step_pulse
);

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRESC_W = $clog2(BASE_PERIOD);

  typedef enum logic [1:0] {
    MODE_SHIFT_L = 2'b00,
    MODE_SHIFT_R = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_FILL    = 2'b11
  } mode_e;

  // Button index: 0 = mode, 1 = speed, 2 = pause.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_pause, btn_speed, btn_mode};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [1:0]       sync_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             prev_q;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_q[1] != stable_q) begin
        if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
          stable_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
        prev_q   <= 1'b0;
      end else begin
        sync_q   <= {sync_q[0], btn_raw[gi]};
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        prev_q   <= stable_q;
      end
    end

    assign press[gi] = stable_q & ~prev_q;
  end

  mode_e               mode_q, mode_d;
  logic [1:0]          speed_q, speed_d;
  logic                paused_q, paused_d;
  logic [7:0]          led_q, led_d;
  logic [2:0]          pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                step_q, step_d;
  logic [PRESC_W-1:0]  period;

  always_comb begin
    period   = PRESC_W'(BASE_PERIOD >> speed_q);
    mode_d   = mode_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    led_d    = led_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    step_d   = 1'b0;

    // Any press restarts the step period and swallows a coincident step.
    if (|press) begin
      presc_d = '0;
      if (press[0]) begin
        mode_d = mode_e'(mode_q + 2'd1);
        led_d  = (mode_d == MODE_SHIFT_R) ? 8'h80 : 8'h01;
        pos_d  = 3'd0;
        dir_d  = 1'b0;
      end
      if (press[1]) speed_d = speed_q + 2'd1;
      if (press[2]) paused_d = ~paused_q;
    end else if (!paused_q) begin
      if (presc_q == period - 1'b1) begin
        presc_d = '0;
        step_d  = 1'b1;
        case (mode_q)
          MODE_SHIFT_L: led_d = {led_q[6:0], led_q[7]};
          MODE_SHIFT_R: led_d = {led_q[0], led_q[7:1]};
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q == 3'd7) begin
                dir_d = 1'b1;
                pos_d = 3'd6;
              end else begin
                pos_d = pos_q + 3'd1;
              end
            end else begin
              if (pos_q == 3'd0) begin
                dir_d = 1'b0;
                pos_d = 3'd1;
              end else begin
                pos_d = pos_q - 3'd1;
              end
            end
            led_d = 8'h01 << pos_d;
          end
          default: led_d = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
        endcase
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_SHIFT_L;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      led_q    <= 8'h01;
      pos_q    <= 3'd0;
      dir_q    <= 1'b0;
      presc_q  <= '0;
      step_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      led_q    <= led_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      presc_q  <= presc_d;
      step_q   <= step_d;
    end
  end

  assign led        = led_q;
  assign mode       = mode_q;
  assign speed      = speed_q;
  assign paused     = paused_q;
  assign step_pulse = step_q;

endmodule
